// File: rtl/if_id_stage.sv
// ============================================================================
// Module   : if_id_stage
// Purpose  : MIPS instruction fetch with PC/next-PC mux and IF/ID register.
//            Optional macro IF_PERF_CNT_EN adds fetch/flush/stall counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
    parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_ready,
    input  logic        i_stall,
    input  logic [2:0]  i_pc_src,
    input  logic [31:0] i_jr_target,
    input  logic        i_ex_br_taken,
    input  logic [31:0] i_ex_br_target,
    input  logic        i_irq_in,
    output logic        o_irq_req,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pc_plus4,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] o_perf_fetch,
    output logic [31:0] o_perf_flush,
    output logic [31:0] o_perf_stall,
`endif
    output logic        o_id_valid
);

    localparam logic [2:0]  c_SRC_JUMP  = 3'd2;
    localparam logic [2:0]  c_SRC_JR    = 3'd3;
    localparam logic [2:0]  c_SRC_ILLOP = 3'd4;
    localparam logic [2:0]  c_SRC_XADR  = 3'd5;
    localparam logic [31:0] c_NOP       = 32'h0000_0000;

    logic [31:0] r_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc_plus4;
    logic        r_id_valid;
    logic        r_irq_pend;

    logic [31:0] w_pc_inc;
    logic [31:0] w_jump_tgt;
    logic [31:0] w_redir_tgt;
    logic        w_redirect;

    logic        w_ev_branch;
    logic        w_ev_hold;
    logic        w_ev_redir;
    logic        w_ev_wait;
    logic        w_ev_fetch;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_id_instr_nxt;
    logic [31:0] w_id_pc_nxt;
    logic [31:0] w_id_pc_plus4_nxt;
    logic        w_id_valid_nxt;
    logic        w_irq_pend_nxt;

    // Increment keeps the kernel bit; only the low 31 bits wrap.
    assign w_pc_inc   = {r_pc[31], r_pc[30:0] + 31'd4};
    assign w_jump_tgt = {r_id_pc[31], r_id_pc_plus4[30:28], r_id_instr[25:0], 2'b00};

    always_comb begin
        w_redirect  = 1'b0;
        w_redir_tgt = r_pc;
        case (i_pc_src)
            c_SRC_JUMP: begin
                w_redirect  = r_id_valid;
                w_redir_tgt = w_jump_tgt;
            end
            c_SRC_JR: begin
                w_redirect  = r_id_valid;
                w_redir_tgt = i_jr_target;
            end
            c_SRC_ILLOP: begin
                w_redirect  = r_id_valid;
                w_redir_tgt = ILLOP_PC;
            end
            c_SRC_XADR: begin
                w_redirect  = r_id_valid;
                w_redir_tgt = XADR_PC;
            end
            default: begin
                w_redirect  = 1'b0;
                w_redir_tgt = r_pc;
            end
        endcase
    end

    // Mutually exclusive per-edge events in priority order.
    assign w_ev_branch = i_ex_br_taken;
    assign w_ev_hold   = ~i_ex_br_taken & i_stall;
    assign w_ev_redir  = ~i_ex_br_taken & ~i_stall & w_redirect;
    assign w_ev_wait   = ~i_ex_br_taken & ~i_stall & ~w_redirect & ~i_imem_ready;
    assign w_ev_fetch  = ~i_ex_br_taken & ~i_stall & ~w_redirect & i_imem_ready;

    always_comb begin
        w_pc_nxt          = r_pc;
        w_id_instr_nxt    = r_id_instr;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_id_valid_nxt    = r_id_valid;
        if (w_ev_branch) begin
            w_pc_nxt       = i_ex_br_target;
            w_id_instr_nxt = c_NOP;
            w_id_valid_nxt = 1'b0;
        end else if (w_ev_hold) begin
            w_pc_nxt       = r_pc;
        end else if (w_ev_redir) begin
            w_pc_nxt       = w_redir_tgt;
            w_id_instr_nxt = c_NOP;
            w_id_valid_nxt = 1'b0;
        end else if (w_ev_wait) begin
            w_id_instr_nxt = c_NOP;
            w_id_valid_nxt = 1'b0;
        end else begin
            w_pc_nxt          = w_pc_inc;
            w_id_instr_nxt    = i_imem_rdata;
            w_id_pc_nxt       = r_pc;
            w_id_pc_plus4_nxt = w_pc_inc;
            w_id_valid_nxt    = 1'b1;
        end
    end

    // Clear wins over a simultaneous set; a held irq_in re-arms next edge.
    always_comb begin
        w_irq_pend_nxt = r_irq_pend | i_irq_in;
        if (w_ev_redir && (i_pc_src == c_SRC_ILLOP)) begin
            w_irq_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_id_instr    <= c_NOP;
            r_id_pc       <= 32'h0;
            r_id_pc_plus4 <= 32'h0;
            r_id_valid    <= 1'b0;
            r_irq_pend    <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_irq_pend    <= w_irq_pend_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= 32'h0;
            r_perf_flush <= 32'h0;
            r_perf_stall <= 32'h0;
        end else begin
            if (w_ev_fetch) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_ev_branch || w_ev_redir) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if (w_ev_hold || w_ev_wait) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_fetch = r_perf_fetch;
    assign o_perf_flush = r_perf_flush;
    assign o_perf_stall = r_perf_stall;
`endif

    assign o_imem_addr   = r_pc;
    assign o_id_instr    = r_id_instr;
    assign o_id_pc       = r_id_pc;
    assign o_id_pc_plus4 = r_id_pc_plus4;
    assign o_id_valid    = r_id_valid;
    // Registered terms only, so no combinational path back through pc_src.
    assign o_irq_req     = r_irq_pend & r_id_valid & ~r_id_pc[31];

endmodule

`default_nettype wire

// File: tb/tb_if_id_stage.sv
// ============================================================================
// Module   : tb_if_id_stage
// Purpose  : Directed self-checking bench for if_id_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic [2:0]  pc_src;
    logic [31:0] jr_target;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        irq_in;
    logic        irq_req;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
    logic [31:0] perf_stall;
`endif

    int n_cmp;
    int n_err;

    if_id_stage u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .o_imem_addr    (imem_addr),
        .i_imem_rdata   (imem_rdata),
        .i_imem_ready   (imem_ready),
        .i_stall        (stall),
        .i_pc_src       (pc_src),
        .i_jr_target    (jr_target),
        .i_ex_br_taken  (ex_br_taken),
        .i_ex_br_target (ex_br_target),
        .i_irq_in       (irq_in),
        .o_irq_req      (irq_req),
        .o_id_instr     (id_instr),
        .o_id_pc        (id_pc),
        .o_id_pc_plus4  (id_pc_plus4),
`ifdef IF_PERF_CNT_EN
        .o_perf_fetch   (perf_fetch),
        .o_perf_flush   (perf_flush),
        .o_perf_stall   (perf_stall),
`endif
        .o_id_valid     (id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        imem_rdata   = 32'h0;
        imem_ready   = 1'b1;
        stall        = 1'b0;
        pc_src       = 3'd0;
        jr_target    = 32'h0;
        ex_br_taken  = 1'b0;
        ex_br_target = 32'h0;
        irq_in       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word);
        idle();
        imem_rdata = word;
        step();
    endtask

    task automatic branch(input logic [31:0] tgt);
        idle();
        ex_br_taken  = 1'b1;
        ex_br_target = tgt;
        step();
        idle();
    endtask

    task automatic chk_id(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                          input logic [31:0] pc, input logic valid);
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".instr"}, id_instr, instr);
        chk({tag, ".pc"},    id_pc, pc);
        chk({tag, ".valid"}, {31'h0, id_valid}, {31'h0, valid});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        #12;
        chk_id("rst", 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        chk("rst.plus4", id_pc_plus4, 32'h0);
        chk("rst.irq", {31'h0, irq_req}, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch from reset vector
        fetch(32'h1111_1111);
        chk_id("seq1", 32'h8000_0004, 32'h1111_1111, 32'h8000_0000, 1'b1);
        fetch(32'h2222_2222);
        chk_id("seq2", 32'h8000_0008, 32'h2222_2222, 32'h8000_0004, 1'b1);
        chk("seq2.plus4", id_pc_plus4, 32'h8000_0008);

        branch(32'h0040_0000);
        chk_id("br", 32'h0040_0000, 32'h0, 32'h8000_0004, 1'b0);
        fetch(32'h0800_0010);
        chk_id("jfetch", 32'h0040_0004, 32'h0800_0010, 32'h0040_0000, 1'b1);

        // Jump decoded in ID
        idle(); pc_src = 3'd2; imem_rdata = 32'hDEAD_0000; step();
        chk_id("jump", 32'h0000_0040, 32'h0, 32'h0040_0000, 1'b0);

        // Redirect request ignored while ID holds a bubble
        idle(); pc_src = 3'd3; jr_target = 32'hDEAD_BEEC; imem_rdata = 32'h3333_3333; step();
        chk_id("nojr_bub", 32'h0000_0044, 32'h3333_3333, 32'h0000_0040, 1'b1);
        idle(); pc_src = 3'd1; imem_rdata = 32'h4444_4444; step();
        chk_id("src1", 32'h0000_0048, 32'h4444_4444, 32'h0000_0044, 1'b1);
        idle(); pc_src = 3'd6; imem_rdata = 32'h4444_5555; step();
        chk_id("src6", 32'h0000_004C, 32'h4444_5555, 32'h0000_0048, 1'b1);

        // Branch overrides stall
        idle(); stall = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h0040_0100; step();
        chk_id("stbr", 32'h0040_0100, 32'h0, 32'h0000_0048, 1'b0);
        idle(); stall = 1'b1; step();
        chk_id("stall", 32'h0040_0100, 32'h0, 32'h0000_0048, 1'b0);
        fetch(32'h5555_5555);
        chk_id("f5", 32'h0040_0104, 32'h5555_5555, 32'h0040_0100, 1'b1);
        idle(); stall = 1'b1; pc_src = 3'd3; jr_target = 32'h1234_5678; step();
        chk_id("stjr", 32'h0040_0104, 32'h5555_5555, 32'h0040_0100, 1'b1);
        idle(); pc_src = 3'd3; jr_target = 32'h1234_5678; step();
        chk_id("jr", 32'h1234_5678, 32'h0, 32'h0040_0100, 1'b0);

        // PC+4 wrap keeps bit 31
        branch(32'h7FFF_FFFC);
        fetch(32'hAAAA_0001);
        chk_id("wrapu", 32'h0000_0000, 32'hAAAA_0001, 32'h7FFF_FFFC, 1'b1);
        chk("wrapu.plus4", id_pc_plus4, 32'h0000_0000);
        branch(32'hFFFF_FFFC);
        fetch(32'hAAAA_0002);
        chk_id("wrapk", 32'h8000_0000, 32'hAAAA_0002, 32'hFFFF_FFFC, 1'b1);
        chk("wrapk.plus4", id_pc_plus4, 32'h8000_0000);

        // User-mode interrupt
        branch(32'h0040_0020);
        idle(); imem_rdata = 32'h6666_6666; irq_in = 1'b1; step();
        chk("irqu.req", {31'h0, irq_req}, 32'h1);
        idle(); pc_src = 3'd4; step();
        chk_id("illop", 32'h8000_0004, 32'h0, 32'h0040_0020, 1'b0);
        branch(32'h0040_0200);
        fetch(32'h6666_7777);
        chk("irqclr.req", {31'h0, irq_req}, 32'h0);
        chk("irqclr.pc", id_pc, 32'h0040_0200);

        // Kernel-mode interrupt stays pending until user PC
        branch(32'h8000_0010);
        idle(); imem_rdata = 32'h7777_7777; irq_in = 1'b1; step();
        chk("irqk1.req", {31'h0, irq_req}, 32'h0);
        chk("irqk1.pc", id_pc, 32'h8000_0010);
        fetch(32'h7777_7778);
        chk("irqk2.req", {31'h0, irq_req}, 32'h0);
        idle(); pc_src = 3'd3; jr_target = 32'h0040_0000; step();
        chk_id("kjr", 32'h0040_0000, 32'h0, 32'h8000_0014, 1'b0);
        fetch(32'h8888_8888);
        chk("irqk3.req", {31'h0, irq_req}, 32'h1);
        idle(); stall = 1'b1; pc_src = 3'd4; step();
        chk("irqst.req", {31'h0, irq_req}, 32'h1);
        chk("irqst.addr", imem_addr, 32'h0040_0004);
        // Set and clear on the same edge resolve to clear
        idle(); pc_src = 3'd4; irq_in = 1'b1; step();
        chk("irqsc.addr", imem_addr, 32'h8000_0004);
        branch(32'h0040_0300);
        fetch(32'h9999_0000);
        chk("irqsc.req", {31'h0, irq_req}, 32'h0);

        // Fetch wait states
        for (int i = 0; i < 3; i++) begin
            idle(); imem_ready = 1'b0; imem_rdata = 32'hBAD0_0000; step();
            chk_id("wait", 32'h0040_0304, 32'h0, 32'h0040_0300, 1'b0);
        end
        fetch(32'h9999_9999);
        chk_id("resume", 32'h0040_0308, 32'h9999_9999, 32'h0040_0304, 1'b1);

        // Asynchronous reset mid-burst
        idle(); imem_ready = 1'b0; step();
        #2 rst_n = 1'b0;
        #1;
        chk_id("arst", 32'h8000_0000, 32'h0, 32'h0, 1'b0);
        chk("arst.plus4", id_pc_plus4, 32'h0);
        #1 rst_n = 1'b1;
        fetch(32'hCAFE_0001);
        chk_id("post", 32'h8000_0004, 32'hCAFE_0001, 32'h8000_0000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.
- Owns the PC and the next-PC mux. Drives the instruction memory address and latches the fetched word.
- Supplies id_instr (OpCode/Funct), id_pc, id_pc_plus4 and the gated interrupt request to the main control unit. Consumes that unit's PCSrc back as pc_src.
- PC[31] is the kernel/supervisor bit: interrupts are masked while it is set.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded at reset.
- ILLOP_PC, 32'h8000_0004, interrupt vector, selected when pc_src=4.
- XADR_PC, 32'h8000_0008, undefined-instruction vector, selected when pc_src=5.

Ports:
- clk  in  1  single core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active low.
- imem_addr  out  32  fetch address; equals the PC register.
- imem_rdata  in  32  instruction word for imem_addr, valid in the same cycle.
- imem_ready  in  1  1 = imem_rdata valid this cycle; 0 = fetch wait.
- stall  in  1  hazard unit load-use stall: hold PC and IF/ID.
- pc_src  in  3  PCSrc from the control unit, decoded from the current id_instr.
- jr_target  in  32  forwarded rs value for jr/jalr.
- ex_br_taken  in  1  branch resolved taken in EX.
- ex_br_target  in  32  branch target from EX.
- irq_in  in  1  external/timer interrupt, level.
- irq_req  out  1  interrupt request to the control unit.
- id_instr  out  32  IF/ID instruction; 0 (sll nop) when a bubble.
- id_pc  out  32  PC of id_instr; EPC source for interrupt/exception.
- id_pc_plus4  out  32  link value for jal/jalr.
- id_valid  out  1  1 = id_instr is a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC.
  - id_instr=0, id_pc=0, id_pc_plus4=0, id_valid=0.
  - irq_pend=0.
- PC+4 arithmetic: inc(x) = {x[31], x[30:0]+4}. Bit 31 never changes by incrementing; bits 30:0 wrap to 0.
- Jump target: {id_pc[31], id_pc_plus4[30:28], id_instr[25:0], 2'b00}.
- jr target: jr_target taken as-is, including bit 31, so jr may leave kernel mode.
- redirect = id_valid & (pc_src in {2,3,4,5}). pc_src 0, 1, 6 and 7 never redirect; branches resolve only via ex_br_taken.
- Per-edge priority:
  1. ex_br_taken: PC=ex_br_target; IF/ID loads a bubble. Overrides stall, since the ID instruction is younger and squashed.
  2. stall: PC and IF/ID held; redirect ignored this cycle and re-evaluated next cycle.
  3. redirect: PC = jump target (2), jr_target (3), ILLOP_PC (4) or XADR_PC (5). IF/ID loads a bubble (matches IF_Flush).
  4. imem_ready=0: PC held; IF/ID loads a bubble.
  5. Otherwise: IF/ID loads {imem_rdata, PC, inc(PC), valid=1}; PC = inc(PC).
- Bubble means id_instr=0, id_valid=0, id_pc and id_pc_plus4 unchanged.
- Fetch latency: an instruction at PC is visible in ID one edge after it is accepted.
- Interrupt handling:
  - irq_pend is set on any edge where irq_in=1.
  - irq_pend clears on the edge where a pc_src=4 redirect is taken, i.e. not pre-empted by ex_br_taken or stall.
  - A set and a clear in the same edge resolve to clear. A still-asserted irq_in re-sets it on the next edge.
  - irq_req = irq_pend & id_valid & ~id_pc[31]. Combinational from registers, so no loop through pc_src.
  - In kernel mode the request stays pending and fires once execution returns to user PC.
- Reset mid-operation: all state returns to reset values immediately; no partial fetch is retained.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined: adds three 32-bit wrapping counters and output ports perf_fetch, perf_flush and perf_stall. Each resets to 0.
  - perf_fetch counts priority-5 loads.
  - perf_flush counts priority 1 or 3 events.
  - perf_stall counts stall or imem_ready=0 cycles when not pre-empted.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset then imem_ready=1 running sequential code: imem_addr goes 0x80000000, 0x80000004, 0x80000008. id_valid=1 from the second edge; id_pc_plus4 = id_pc+4.
- Jump: id_instr=0x08000010 with id_pc=0x00400000 and pc_src=2 → next PC=0x00000040 (bit 31 from id_pc=0); ID holds a bubble for one cycle.
- Stall with ex_br_taken together: stall=1, ex_br_taken=1, ex_br_target=0x00400100 → PC=0x00400100, ID bubble. Next, stall=1 alone → PC and ID frozen for the cycle.
- IRQ in user mode: irq_in pulsed 1 cycle while id_pc=0x00400020 → irq_req=1. With pc_src=4 → PC=0x80000004, irq_pend cleared, id_pc still 0x00400020 in the redirect cycle.
- IRQ in kernel mode: irq_in=1 while id_pc=0x80000010 → irq_req=0 and stays pending. After jr to 0x00400000 reaches ID, irq_req=1.
- imem_ready=0 for 3 cycles → imem_addr constant, 3 bubbles (id_instr=0); fetch resumes at the same PC. Reset asserted mid-burst → PC=0x80000000 and id_valid=0 asynchronously.
